// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pipelined control unit.
// BRANCH_DECODE_EN (in ctrl_decode) enables beq decode; the default build treats beq as illegal.
package ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b11;

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               reg_write;
        logic               mem_to_reg;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // Instructions that read rt as a source operand; beq counts regardless of the decode option.
    function automatic logic uses_rt(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/pipelined_control_if.sv
// ID-stage request and stage-control bundle between the control unit and the pipeline.
interface pipelined_control_if;
    import ctrl_pkg::*;

    logic                 Valid_i;
    logic [OP_W-1:0]      Op_i;
    logic [REG_AW-1:0]    Rs_i;
    logic [REG_AW-1:0]    Rt_i;
    logic                 Flush_i;
    logic                 Hold_i;

    logic                 RegDst_o;
    logic                 ALUSrc_o;
    logic [ALUOP_W-1:0]   ALUOp_o;
    logic                 MemRead_o;
    logic                 MemWrite_o;
    logic                 Branch_o;
    logic                 RegWrite_o;
    logic                 MemtoReg_o;
    logic                 Stall_o;
    logic                 Illegal_o;

    modport master (
        output Valid_i, Op_i, Rs_i, Rt_i, Flush_i, Hold_i,
        input  RegDst_o, ALUSrc_o, ALUOp_o, MemRead_o, MemWrite_o, Branch_o,
               RegWrite_o, MemtoReg_o, Stall_o, Illegal_o
    );

    modport slave (
        input  Valid_i, Op_i, Rs_i, Rt_i, Flush_i, Hold_i,
        output RegDst_o, ALUSrc_o, ALUOp_o, MemRead_o, MemWrite_o, Branch_o,
               RegWrite_o, MemtoReg_o, Stall_o, Illegal_o
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode to control bundle plus illegal flag.
// Define BRANCH_DECODE_EN to decode beq; otherwise beq is reported illegal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output ctrl_bundle_t    bundle_o,
    output logic            illegal_o
);

    always_comb begin
        bundle_o  = BUBBLE;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                bundle_o.reg_dst   = 1'b1;
                bundle_o.alu_op    = ALUOP_FUNCT;
                bundle_o.reg_write = 1'b1;
            end
            OP_ADDI: begin
                bundle_o.alu_src   = 1'b1;
                bundle_o.alu_op    = ALUOP_ADD;
                bundle_o.reg_write = 1'b1;
            end
            OP_LW: begin
                bundle_o.alu_src    = 1'b1;
                bundle_o.alu_op     = ALUOP_ADD;
                bundle_o.mem_read   = 1'b1;
                bundle_o.reg_write  = 1'b1;
                bundle_o.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                bundle_o.alu_src   = 1'b1;
                bundle_o.alu_op    = ALUOP_ADD;
                bundle_o.mem_write = 1'b1;
            end
`ifdef BRANCH_DECODE_EN
            OP_BEQ: begin
                bundle_o.alu_op = ALUOP_SUB;
                bundle_o.branch = 1'b1;
            end
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control.sv
// Pipelined control unit: decodes ID opcode and carries control through ID/EX, EX/MEM, MEM/WB,
// with load-use stall, flush and hold. Optional beq decode via BRANCH_DECODE_EN (see ctrl_decode).
module pipelined_control
    import ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    pipelined_control_if.slave bus
);

    ctrl_bundle_t      dec_bundle;
    logic              dec_illegal;

    ctrl_bundle_t      idex_q, idex_d;
    ctrl_bundle_t      exmem_q, exmem_d;
    ctrl_bundle_t      memwb_q, memwb_d;
    logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
    logic              illegal_q, illegal_d;

    logic              stall;
    logic              rt_hit;
    logic              insert_bubble;

    ctrl_decode u_decode (
        .op_i      (bus.Op_i),
        .bundle_o  (dec_bundle),
        .illegal_o (dec_illegal)
    );

    // Load-use hazard: a load in EX whose destination feeds the instruction now in ID.
    always_comb begin
        rt_hit = uses_rt(bus.Op_i) && (idex_rt_q == bus.Rt_i);
        stall  = bus.Valid_i && idex_q.mem_read && (idex_rt_q != '0)
                 && ((idex_rt_q == bus.Rs_i) || rt_hit);
        insert_bubble = bus.Flush_i || stall || !bus.Valid_i;
    end

    always_comb begin
        idex_d    = idex_q;
        idex_rt_d = idex_rt_q;
        illegal_d = illegal_q;
        exmem_d   = exmem_q;
        memwb_d   = memwb_q;
        if (!bus.Hold_i) begin
            exmem_d = idex_q;
            memwb_d = exmem_q;
            if (insert_bubble) begin
                idex_d    = BUBBLE;
                idex_rt_d = '0;
                illegal_d = 1'b0;
            end else begin
                idex_d    = dec_bundle;
                idex_rt_d = bus.Rt_i;
                illegal_d = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_q    <= BUBBLE;
            exmem_q   <= BUBBLE;
            memwb_q   <= BUBBLE;
            idex_rt_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            idex_rt_q <= idex_rt_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.RegDst_o   = idex_q.reg_dst;
    assign bus.ALUSrc_o   = idex_q.alu_src;
    assign bus.ALUOp_o    = idex_q.alu_op;
    assign bus.MemRead_o  = exmem_q.mem_read;
    assign bus.MemWrite_o = exmem_q.mem_write;
    assign bus.Branch_o   = exmem_q.branch;
    assign bus.RegWrite_o = memwb_q.reg_write;
    assign bus.MemtoReg_o = memwb_q.mem_to_reg;
    assign bus.Stall_o    = stall;
    assign bus.Illegal_o  = illegal_q;

endmodule
